pipe_addsub: RTL and testbench

Parametrised, group-pipelined two's-complement adder/subtractor. It replaces the fixed 32-bit combinational add/sub with a WIDTH-bit datapath split into GROUP-bit slices, one register stage per slice. A valid/ready handshake on both sides provides one result per cycle at full throughput. Status flags are added for use by the ALU and the comparator logic downstream.

---
 rtl/pipe_addsub_if.sv | 28 ++
 rtl/pipe_addsub.sv | 124 ++++++++++++
 tb/tb_pipe_addsub.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Handshake and data bundle for the pipelined adder/subtractor.
// The producer/consumer side takes master; the datapath takes slave.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipe_addsub.sv
// Group-pipelined two's-complement add/sub: one GROUP-bit slice per register stage,
// global-enable pipeline with valid/ready handshake on both sides.
module pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 8
) (
    input logic          clk,
    input logic          rst,
    pipe_addsub_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP;

    if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be a non-zero multiple of GROUP");
    end

    logic             stall;
    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign advance      = !stall;
    assign bus.in_ready = advance;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        localparam int unsigned SW = (k + 1) * GROUP;

        logic              vld_q;
        logic              c_q;
        logic [SW-1:0]     s_q;
        logic              v_in;
        logic              c_in;
        logic [GROUP-1:0]  ga;
        logic [GROUP-1:0]  gb;
        logic [GROUP:0]    gs;
        logic [SW-1:0]     s_next;

        if (k == 0) begin : g_src
            assign v_in   = bus.in_valid;
            assign c_in   = bus.sub;
            assign ga     = bus.a[GROUP-1:0];
            assign gb     = b_eff[GROUP-1:0];
            assign s_next = gs[GROUP-1:0];
        end else begin : g_src
            assign v_in   = g_stage[k-1].vld_q;
            assign c_in   = g_stage[k-1].c_q;
            assign ga     = g_stage[k-1].g_fwd.ua_q[GROUP-1:0];
            assign gb     = g_stage[k-1].g_fwd.ub_q[GROUP-1:0];
            assign s_next = {gs[GROUP-1:0], g_stage[k-1].s_q};
        end

        assign gs = {1'b0, ga} + {1'b0, gb} + {{GROUP{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                // Bubbles leave data untouched so stale outputs stay stable.
                if (v_in) begin
                    c_q <= gs[GROUP];
                    s_q <= s_next;
                end
            end
        end

        // Operand groups not yet consumed travel alongside their partial sum.
        if (k < NG - 1) begin : g_fwd
            localparam int unsigned UW = WIDTH - (k + 1) * GROUP;

            logic [UW-1:0] ua_q;
            logic [UW-1:0] ub_q;
            logic [UW-1:0] ua_d;
            logic [UW-1:0] ub_d;

            if (k == 0) begin : g_first
                assign ua_d = bus.a[WIDTH-1:GROUP];
                assign ub_d = b_eff[WIDTH-1:GROUP];
            end else begin : g_next
                assign ua_d = g_stage[k-1].g_fwd.ua_q[UW+GROUP-1:GROUP];
                assign ub_d = g_stage[k-1].g_fwd.ub_q[UW+GROUP-1:GROUP];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ua_q <= '0;
                    ub_q <= '0;
                end else if (advance && v_in) begin
                    ua_q <= ua_d;
                    ub_q <= ub_d;
                end
            end
        end

        if (k == NG - 1) begin : g_last
            logic ovf_q;
            logic zero_q;
            logic neg_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else if (advance && v_in) begin
                    // Carry into the MSB is recovered from the MSB's own sum bit.
                    ovf_q  <= ga[GROUP-1] ^ gb[GROUP-1] ^ gs[GROUP-1] ^ gs[GROUP];
                    zero_q <= (s_next == '0);
                    neg_q  <= gs[GROUP-1];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[NG-1].vld_q;
    assign bus.sum       = g_stage[NG-1].s_q;
    assign bus.cout      = g_stage[NG-1].c_q;
    assign bus.ovf       = g_stage[NG-1].g_last.ovf_q;
    assign bus.zero      = g_stage[NG-1].g_last.zero_q;
    assign bus.neg       = g_stage[NG-1].g_last.neg_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at 32/8, 16/4 and 8/8; flags compared as {cout,ovf,zero,neg}.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] drv_a, drv_b;
    logic        drv_sub, drv_valid, drv_ready;
    int          sel;
    int          nvec = 0;
    int          nfail = 0;

    logic        obs_valid, obs_in_ready;
    logic [63:0] obs_sum;
    logic [3:0]  obs_flags;

    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(32)) if32 ();
    pipe_addsub_if #(.WIDTH(16)) if16 ();
    pipe_addsub_if #(.WIDTH(8))  if8 ();

    pipe_addsub #(.WIDTH(32), .GROUP(8)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    pipe_addsub #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    pipe_addsub #(.WIDTH(8),  .GROUP(8)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    assign if32.a = drv_a[31:0];
    assign if32.b = drv_b[31:0];
    assign if32.sub = drv_sub;
    assign if32.in_valid = drv_valid && (sel == 0);
    assign if32.out_ready = drv_ready;
    assign if16.a = drv_a[15:0];
    assign if16.b = drv_b[15:0];
    assign if16.sub = drv_sub;
    assign if16.in_valid = drv_valid && (sel == 1);
    assign if16.out_ready = drv_ready;
    assign if8.a = drv_a[7:0];
    assign if8.b = drv_b[7:0];
    assign if8.sub = drv_sub;
    assign if8.in_valid = drv_valid && (sel == 2);
    assign if8.out_ready = drv_ready;

    always_comb begin
        obs_valid    = 1'b0;
        obs_in_ready = 1'b0;
        obs_sum      = '0;
        obs_flags    = '0;
        case (sel)
            0: begin
                obs_valid = if32.out_valid; obs_in_ready = if32.in_ready;
                obs_sum = 64'(if32.sum);
                obs_flags = {if32.cout, if32.ovf, if32.zero, if32.neg};
            end
            1: begin
                obs_valid = if16.out_valid; obs_in_ready = if16.in_ready;
                obs_sum = 64'(if16.sum);
                obs_flags = {if16.cout, if16.ovf, if16.zero, if16.neg};
            end
            default: begin
                obs_valid = if8.out_valid; obs_in_ready = if8.in_ready;
                obs_sum = 64'(if8.sum);
                obs_flags = {if8.cout, if8.ovf, if8.zero, if8.neg};
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"}, 64'({obs_valid, obs_in_ready}), 64'b01);
        chk({tag, "_sum"}, obs_sum, 64'd0);
        chk({tag, "_flags"}, 64'(obs_flags), 64'd0);
    endtask

    // Apply one op with out_ready high; measure cycles from presentation to out_valid.
    task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [63:0] esum, input logic [3:0] eflags,
                          input int elat);
        int lat;
        drv_a = a; drv_b = b; drv_sub = s; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_sum"}, obs_sum, esum);
        chk({tag, "_flags"}, 64'(obs_flags), 64'(eflags));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  flags;
    } res_t;

    function automatic res_t model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t        r;
        logic [31:0] be;
        logic [32:0] t;
        be = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {32'd0, s};
        r.sum   = 64'(t[31:0]);
        r.flags = {t[32], (a[31] == be[31]) && (t[31] != a[31]), t[31:0] == 32'd0, t[31]};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        q[$];
        res_t        m, e;
        logic [67:0] hold;
        logic [31:0] ra, rb;
        logic        rs, have, seen;
        int          sent, got, cyc;

        sel = 0; drv_a = '0; drv_b = '0; drv_sub = 1'b0; drv_valid = 1'b0; drv_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk_reset_state("rst32");
        sel = 1; #1;
        chk_reset_state("rst16");
        sel = 2; #1;
        chk_reset_state("rst8");
        sel = 0;
        @(posedge clk); #1;

        single("add_5_3",   64'd5,          64'd3, 1'b0, 64'd8,          4'b0000, 4);
        single("carry_all", 64'hFFFF_FFFF,  64'd1, 1'b0, 64'd0,          4'b1010, 4);
        single("sub_borrow",64'd0,          64'd1, 1'b1, 64'hFFFF_FFFF,  4'b0001, 4);
        single("sub_ovf",   64'h8000_0000,  64'd1, 1'b1, 64'h7FFF_FFFF,  4'b1100, 4);
        single("add_ovf",   64'h7FFF_FFFF,  64'd1, 1'b0, 64'h8000_0000,  4'b0101, 4);
        single("sub_eq",    64'h1234_5678,  64'h1234_5678, 1'b1, 64'd0,  4'b1010, 4);

        // Back-to-back stream with a 3-cycle consumer stall in the middle.
        sent = 0; got = 0; cyc = 0; have = 1'b0; hold = '0;
        while (got < 20 && cyc < 80) begin
            if (sent < 20 && !have) begin
                ra = $urandom; rb = $urandom; rs = 1'(($urandom_range(0, 1)));
                drv_a = 64'(ra); drv_b = 64'(rb); drv_sub = rs;
                have = 1'b1;
            end
            drv_valid = have;
            drv_ready = !(cyc >= 8 && cyc <= 10);
            #1;
            chk("stream_in_ready", 64'(obs_in_ready), (cyc >= 8 && cyc <= 10) ? 64'd0 : 64'd1);
            if (cyc == 8) hold = {obs_flags, obs_sum};
            if (cyc == 9 || cyc == 10) begin
                chk("stall_valid", 64'(obs_valid), 64'd1);
                chk("stall_sum", obs_sum, hold[63:0]);
                chk("stall_flags", 64'(obs_flags), 64'(hold[67:64]));
            end
            if (obs_valid && drv_ready) begin
                e = (q.size() > 0) ? q.pop_front() : '{sum: 64'hDEAD, flags: 4'hF};
                chk("stream_sum", obs_sum, e.sum);
                chk("stream_flags", 64'(obs_flags), 64'(e.flags));
                got++;
            end
            if (drv_valid && obs_in_ready) begin
                m = model32(drv_a[31:0], drv_b[31:0], drv_sub);
                q.push_back(m);
                sent++;
                have = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_count", 64'(got), 64'd20);
        drv_valid = 1'b0; drv_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset with three ops in flight: none of them may ever emerge.
        for (int i = 0; i < 3; i++) begin
            drv_a = 64'(100 * i + 1); drv_b = 64'd7; drv_sub = 1'b0; drv_valid = 1'b1;
            @(posedge clk); #1;
        end
        drv_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (obs_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_flush_valid", 64'(seen), 64'd0);
        single("post_rst", 64'h11, 64'h22, 1'b0, 64'h33, 4'b0000, 4);

        sel = 1; #1;
        single("w16_carry", 64'hFFFF, 64'd1,      1'b0, 64'd0,     4'b1010, 4);
        single("w16_subov", 64'h8000, 64'd1,      1'b1, 64'h7FFF,  4'b1100, 4);
        single("w16_addov", 64'h7FFF, 64'd1,      1'b0, 64'h8000,  4'b0101, 4);
        single("w16_add",   64'h1234, 64'h4321,   1'b0, 64'h5555,  4'b0000, 4);
        single("w16_borrow",64'd0,    64'd1,      1'b1, 64'hFFFF,  4'b0001, 4);

        sel = 2; #1;
        single("w8_carry",  64'hFF,   64'd1,      1'b0, 64'd0,     4'b1010, 1);
        single("w8_subov",  64'h80,   64'd1,      1'b1, 64'h7F,    4'b1100, 1);
        single("w8_addov",  64'h7F,   64'd1,      1'b0, 64'h80,    4'b0101, 1);
        single("w8_sub_eq", 64'd5,    64'd5,      1'b1, 64'd0,     4'b1010, 1);
        single("w8_add",    64'h10,   64'h20,     1'b0, 64'h30,    4'b0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
